// File: rtl/scan_chain_ctrl_if.sv
// Test-engine side request/response bundle for scan_chain_ctrl.
// Parity signals exist only when SCAN_CHAIN_CTRL_PARITY_EN is defined.
interface scan_chain_ctrl_if #(
   parameter int CHAIN_LEN = 8
);
   logic                 start;
   logic                 capture_en;
   logic [CHAIN_LEN-1:0] load_data;
   logic                 busy;
   logic                 done;
   logic [CHAIN_LEN-1:0] unload_data;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
   logic                 parity_exp;
   logic                 parity_err;
`endif

   modport master (
      output start, capture_en, load_data,
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
      output parity_exp,
      input  parity_err,
`endif
      input  busy, done, unload_data
   );

   modport slave (
      input  start, capture_en, load_data,
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
      input  parity_exp,
      output parity_err,
`endif
      output busy, done, unload_data
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Load / optional capture / unload sequencer for one muxed-D scan chain.
// Optional unload parity check enabled by defining SCAN_CHAIN_CTRL_PARITY_EN.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 8
) (
   input  logic              CLK,
   input  logic              RN,
   scan_chain_ctrl_if.slave  bus,
   output logic              SE,
   output logic              SI,
   input  logic              SO
);
   localparam int CNT_W = $clog2(CHAIN_LEN);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_IN  = 3'd1,
      S_CAPTURE   = 3'd2,
      S_SHIFT_OUT = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] ld_sr_q, ld_sr_d;
   logic [CHAIN_LEN-1:0] unl_sr_q, unl_sr_d;
   logic [CHAIN_LEN-1:0] unload_q, unload_d;
   logic                 cap_q, cap_d;
   logic                 se_q, se_d;
   logic                 si_q, si_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 last_s;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
   logic                 par_exp_q, par_exp_d;
   logic                 par_err_q, par_err_d;

   function automatic logic parity_f(input logic [CHAIN_LEN-1:0] v);
      return ^v;
   endfunction
`endif

   assign last_s = (cnt_q == CNT_W'(CHAIN_LEN - 1));

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_sr_d  = ld_sr_q;
      unl_sr_d = unl_sr_q;
      unload_d = unload_q;
      cap_d    = cap_q;
      se_d     = 1'b0;
      si_d     = 1'b0;
      done_d   = 1'b0;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
      par_exp_d = par_exp_q;
      par_err_d = par_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ld_sr_d = bus.load_data;
               cap_d   = bus.capture_en;
               cnt_d   = '0;
               state_d = S_SHIFT_IN;
               se_d    = 1'b1;
               si_d    = bus.load_data[CHAIN_LEN-1];
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
               par_exp_d = bus.parity_exp;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT_IN: begin
            // SI is one register ahead, so present the next-lower bit for the coming cycle
            ld_sr_d = {ld_sr_q[CHAIN_LEN-2:0], 1'b0};
            if (last_s) begin
               cnt_d = '0;
               if (cap_q) begin
                  state_d = S_CAPTURE;
               end else begin
                  state_d = S_SHIFT_OUT;
                  se_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               se_d  = 1'b1;
               si_d  = ld_sr_q[CHAIN_LEN-2];
            end
         end
         S_CAPTURE: begin
            state_d = S_SHIFT_OUT;
            se_d    = 1'b1;
         end
         S_SHIFT_OUT: begin
            unl_sr_d = {unl_sr_q[CHAIN_LEN-2:0], SO};
            if (last_s) begin
               cnt_d    = '0;
               state_d  = S_DONE;
               done_d   = 1'b1;
               unload_d = unl_sr_d;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
               par_err_d = (parity_f(unl_sr_d) != par_exp_q);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               se_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ld_sr_q  <= '0;
         unl_sr_q <= '0;
         unload_q <= '0;
         cap_q    <= 1'b0;
         se_q     <= 1'b0;
         si_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
         par_exp_q <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ld_sr_q  <= ld_sr_d;
         unl_sr_q <= unl_sr_d;
         unload_q <= unload_d;
         cap_q    <= cap_d;
         se_q     <= se_d;
         si_q     <= si_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
         par_exp_q <= par_exp_d;
         par_err_q <= par_err_d;
`endif
      end
   end

   assign SE              = se_q;
   assign SI              = si_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.unload_data = unload_q;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
   assign bus.parity_err  = par_err_q;
`endif
endmodule
